kronos_cx_unit: RTL and testbench

//  Multi-channel custom-instruction (CUSTOM-0) dispatch unit for the Kronos EX stage; replaces the single-MAC

---
 rtl/kronos_cx_unit_if.sv | 37 +++
 rtl/kronos_cx_unit.sv | 193 +++++++++++++++++++
 tb/tb_kronos_cx_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kronos_cx_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : kronos_cx_unit_if
//  Purpose  : Coprocessor bus between the CUSTOM-0 dispatch unit and its
//             NUM_CH coprocessors. Per-channel request/response valid/ready,
//             shared request payload, per-channel 32-bit response data.
//  Ports    : req_valid/req_ready  per-channel request handshake
//             req_funct7/rs1/rs2   shared request payload
//             rsp_valid/rsp_ready  per-channel response handshake
//             rsp_rd               response data, channel c in [32c+:32]
//  Revision : 1.0  initial release
// ============================================================================
interface kronos_cx_unit_if #(
    parameter int NUM_CH = 2
) ();
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [6:0]           req_funct7;
    logic [31:0]          req_rs1;
    logic [31:0]          req_rs2;
    logic [NUM_CH-1:0]    rsp_valid;
    logic [32*NUM_CH-1:0] rsp_rd;
    logic [NUM_CH-1:0]    rsp_ready;

    // Dispatch unit side
    modport master (
        output req_valid, req_funct7, req_rs1, req_rs2, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd
    );

    // Coprocessor side
    modport slave (
        input  req_valid, req_funct7, req_rs1, req_rs2, rsp_ready,
        output req_ready, rsp_valid, rsp_rd
    );
endinterface
`default_nettype wire

// File: rtl/kronos_cx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : kronos_cx_unit
//  Purpose  : CUSTOM-0 dispatch unit for the Kronos EX stage. Latches one
//             custom instruction, routes it by funct3 to one of NUM_CH
//             coprocessors with full valid/ready handshakes, and returns the
//             result or an error code. One instruction in flight, blocking.
//  Ports    : clk, rstz (async, active-low)
//             i_cx_vld/ir/op1/op2  instruction from EX
//             i_cx_abort           trap/flush, abandon current instruction
//             o_cx_busy            unit not idle
//             o_cx_done/error      one-cycle completion pulse / failure flag
//             o_cx_err_code        00 none, 01 bad opcode/channel, 10 timeout
//             o_cx_regwr/rd/result writeback request, register, data
//             cop                  coprocessor bus (master modport)
//  Revision : 1.0  initial release
// ============================================================================
module kronos_cx_unit #(
    parameter int         NUM_CH  = 2,
    parameter logic [4:0] OPCODE  = 5'b00010,
    parameter int         TIMEOUT = 256
) (
    input  wire logic        clk,
    input  wire logic        rstz,
    input  wire logic        i_cx_vld,
    input  wire logic [31:0] i_cx_ir,
    input  wire logic [31:0] i_cx_op1,
    input  wire logic [31:0] i_cx_op2,
    input  wire logic        i_cx_abort,
    output logic             o_cx_busy,
    output logic             o_cx_done,
    output logic             o_cx_error,
    output logic [1:0]       o_cx_err_code,
    output logic             o_cx_regwr,
    output logic [4:0]       o_cx_rd,
    output logic [31:0]      o_cx_result,
    kronos_cx_unit_if.master cop
);

    // Counter keeps at least one bit so TIMEOUT=0 (disabled) still elaborates.
    localparam int             c_CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RSP   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_ch;
    logic [4:0]        r_rd;
    logic [6:0]        r_funct7;
    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic [31:0]       r_result;
    logic [1:0]        r_err_code;
    logic [c_CW-1:0]   r_cnt;

    logic [NUM_CH-1:0] w_ch_sel;
    logic              w_accept;
    logic              w_bad;
    logic              w_req_hs;
    logic              w_rsp_hs;
    logic              w_timeout;
    logic [31:0]       w_rsp_data;
    logic              w_unused_ir;

    assign w_unused_ir = ^{i_cx_ir[24:15], i_cx_ir[1:0]};

    assign w_ch_sel  = NUM_CH'(1) << r_ch;
    assign w_accept  = (r_state == S_IDLE) && i_cx_vld;
    assign w_bad     = (i_cx_ir[6:2] != OPCODE) ||
                       ({29'd0, i_cx_ir[14:12]} >= 32'(NUM_CH));
    assign w_req_hs  = (r_state == S_REQ) && |(cop.req_ready & w_ch_sel);
    assign w_rsp_hs  = ((r_state == S_RSP) || (r_state == S_DRAIN)) &&
                       |(cop.rsp_valid & w_ch_sel);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

    // Only the selected channel's response data is ever looked at.
    always_comb begin
        w_rsp_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == 3'(c)) begin
                w_rsp_data = cop.rsp_rd[32*c +: 32];
            end
        end
    end

    // Next-state logic. Handshakes take priority over timeout. An abort that
    // coincides with a request handshake still has a response in flight, so
    // it goes through DRAIN; an abort coinciding with the response handshake
    // has nothing left outstanding and returns straight to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cx_vld) begin
                    w_state_nxt = w_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = i_cx_abort ? S_DRAIN : S_RSP;
                end else if (i_cx_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = i_cx_abort ? S_IDLE : S_DONE;
                end else if (i_cx_abort) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DRAIN: begin
                if (w_rsp_hs || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_ch       <= '0;
            r_rd       <= '0;
            r_funct7   <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_result   <= '0;
            r_err_code <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_ch       <= i_cx_ir[14:12];
                r_rd       <= i_cx_ir[11:7];
                r_funct7   <= i_cx_ir[31:25];
                r_op1      <= i_cx_op1;
                r_op2      <= i_cx_op2;
                r_err_code <= w_bad ? 2'b01 : 2'b00;
                r_cnt      <= '0;
            end else begin
                if ((r_state == S_REQ) || (r_state == S_RSP) || (r_state == S_DRAIN)) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
                // Any route into ERR other than from IDLE is a timeout.
                if (w_state_nxt == S_ERR) begin
                    r_err_code <= 2'b10;
                end
                if (w_state_nxt == S_DONE) begin
                    r_result <= w_rsp_data;
                end
            end
        end
    end

    // Handshake outputs decode from state so an async reset drops them at once.
    assign cop.req_valid  = (r_state == S_REQ) ? w_ch_sel : '0;
    assign cop.rsp_ready  = ((r_state == S_RSP) || (r_state == S_DRAIN)) ? w_ch_sel : '0;
    assign cop.req_funct7 = r_funct7;
    assign cop.req_rs1    = r_op1;
    assign cop.req_rs2    = r_op2;

    assign o_cx_busy      = (r_state != S_IDLE);
    assign o_cx_done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign o_cx_error     = (r_state == S_ERR);
    assign o_cx_regwr     = (r_state == S_DONE) && (r_rd != 5'd0);
    assign o_cx_err_code  = r_err_code;
    assign o_cx_rd        = r_rd;
    assign o_cx_result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_kronos_cx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kronos_cx_unit
//  Purpose  : Directed self-checking bench for kronos_cx_unit (NUM_CH=2,
//             TIMEOUT=16). The bench plays the coprocessors by hand.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kronos_cx_unit;

    localparam int         NUM_CH  = 2;
    localparam int         TIMEOUT = 16;
    localparam logic [4:0] OPC     = 5'b00010;

    logic        clk = 1'b0;
    logic        rstz;
    logic        cx_vld, cx_abort;
    logic [31:0] cx_ir, cx_op1, cx_op2;
    logic        cx_busy, cx_done, cx_error, cx_regwr;
    logic [1:0]  cx_err_code;
    logic [4:0]  cx_rd;
    logic [31:0] cx_result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kronos_cx_unit_if #(.NUM_CH(NUM_CH)) cop ();

    kronos_cx_unit #(.NUM_CH(NUM_CH), .OPCODE(OPC), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .i_cx_vld      (cx_vld),
        .i_cx_ir       (cx_ir),
        .i_cx_op1      (cx_op1),
        .i_cx_op2      (cx_op2),
        .i_cx_abort    (cx_abort),
        .o_cx_busy     (cx_busy),
        .o_cx_done     (cx_done),
        .o_cx_error    (cx_error),
        .o_cx_err_code (cx_err_code),
        .o_cx_regwr    (cx_regwr),
        .o_cx_rd       (cx_rd),
        .o_cx_result   (cx_result),
        .cop           (cop)
    );

    function automatic logic [31:0] mk_ir(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] op5);
        return {f7, 5'd2, 5'd1, f3, rd, op5, 2'b11};
    endfunction

    // {busy, done, error, regwr}
    function automatic logic [3:0] status();
        return {cx_busy, cx_done, cx_error, cx_regwr};
    endfunction

    // Advance into the next cycle; checks made here sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cx_vld        = 1'b0;
        cx_abort      = 1'b0;
        cop.req_ready = '0;
        cop.rsp_valid = '0;
        cop.rsp_rd    = '0;
    endtask

    task automatic test_reset();
        rstz = 1'b0; cx_ir = '0; cx_op1 = '0; cx_op2 = '0; quiet();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({status(), cx_err_code, cx_rd, cx_result} !== 43'd0) begin
            n_err++; $display("FAIL reset_outs: got %h want 0", {status(), cx_err_code, cx_rd, cx_result});
        end
        n_vec++;
        if ({cop.req_valid, cop.rsp_ready, cop.req_funct7, cop.req_rs1, cop.req_rs2} !== '0) begin
            n_err++; $display("FAIL reset_bus: got req_valid=%b rsp_ready=%b want 0", cop.req_valid, cop.rsp_ready);
        end
        @(negedge clk); rstz = 1'b1;
        step();
    endtask

    task automatic test_basic();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h05, 3'd1, 5'd5, OPC); cx_op1 = 32'd3; cx_op2 = 32'd4;
        n_vec++;
        if (status() !== 4'b0000) begin n_err++; $display("FAIL basic_idle: got %b want 0000", status()); end
        step();  // T+1
        cx_vld = 1'b0; cop.req_ready = 2'b10;
        n_vec++;
        if (cop.req_valid !== 2'b10) begin n_err++; $display("FAIL basic_req_valid: got %b want 10", cop.req_valid); end
        n_vec++;
        if ({cop.req_funct7, cop.req_rs1, cop.req_rs2} !== {7'h05, 32'd3, 32'd4}) begin
            n_err++; $display("FAIL basic_payload: got %h/%h/%h want 05/3/4", cop.req_funct7, cop.req_rs1, cop.req_rs2);
        end
        step();  // T+2
        cop.req_ready = '0; cop.rsp_valid = 2'b10; cop.rsp_rd = {32'h0000_000C, 32'h0};
        n_vec++;
        if ({cop.rsp_ready, cop.req_valid} !== 4'b1000) begin
            n_err++; $display("FAIL basic_rsp_ready: got %b/%b want 10/00", cop.rsp_ready, cop.req_valid);
        end
        step();  // T+3
        cop.rsp_valid = '0;
        n_vec++;
        if (status() !== 4'b1101) begin n_err++; $display("FAIL basic_done: got %b want 1101", status()); end
        n_vec++;
        if ({cx_result, cx_rd, cx_err_code} !== {32'hC, 5'd5, 2'b00}) begin
            n_err++; $display("FAIL basic_result: got %h rd=%0d want c rd=5", cx_result, cx_rd);
        end
        step();  // T+4
        n_vec++;
        if (status() !== 4'b0000) begin n_err++; $display("FAIL basic_after: got %b want 0000", status()); end
    endtask

    task automatic test_stall();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h11, 3'd0, 5'd7, OPC); cx_op1 = 32'hA5A5_A5A5; cx_op2 = 32'h5A5A_5A5A;
        for (int i = 1; i <= 6; i++) begin
            step();
            cx_vld = 1'b0;
            cop.req_ready = (i == 6) ? 2'b01 : 2'b00;
            n_vec++;
            if ({cop.req_valid, cop.req_funct7, cop.req_rs1, cop.req_rs2} !==
                {2'b01, 7'h11, 32'hA5A5_A5A5, 32'h5A5A_5A5A}) begin
                n_err++; $display("FAIL stall_req_c%0d: got %b/%h/%h/%h want 01/11/a5a5a5a5/5a5a5a5a",
                                  i, cop.req_valid, cop.req_funct7, cop.req_rs1, cop.req_rs2);
            end
        end
        step();  // T+7
        cop.req_ready = '0; cop.rsp_valid = 2'b01; cop.rsp_rd = {32'h0, 32'h0000_1234};
        step();  // T+8
        cop.rsp_valid = '0;
        n_vec++;
        if ({status(), cx_result, cx_rd} !== {4'b1101, 32'h1234, 5'd7}) begin
            n_err++; $display("FAIL stall_done: got %b %h %0d want 1101 1234 7", status(), cx_result, cx_rd);
        end
        step();
    endtask

    task automatic test_bad_instr();
        logic [31:0] irs [2];
        irs[0] = mk_ir(7'h00, 3'd3, 5'd4, OPC);
        irs[1] = mk_ir(7'h00, 3'd0, 5'd4, 5'b01010);
        for (int k = 0; k < 2; k++) begin
            cx_vld = 1'b1; cx_ir = irs[k];
            step();  // T+1
            cx_vld = 1'b0;
            n_vec++;
            if ({cop.req_valid, status(), cx_err_code} !== {2'b00, 4'b1110, 2'b01}) begin
                n_err++; $display("FAIL bad_err_%0d: got rv=%b st=%b code=%b want 00 1110 01",
                                  k, cop.req_valid, status(), cx_err_code);
            end
            step();  // T+2
            n_vec++;
            if ({status(), cx_err_code} !== {4'b0000, 2'b01}) begin
                n_err++; $display("FAIL bad_hold_%0d: got %b/%b want 0000/01", k, status(), cx_err_code);
            end
        end
    endtask

    task automatic test_timeout();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd0, 5'd3, OPC);
        step();  // T+1: first REQ cycle
        cx_vld = 1'b0; cop.req_ready = 2'b01;
        for (int k = 2; k <= 16; k++) begin
            step();
            cop.req_ready = '0;
            n_vec++;
            if ({status(), cop.rsp_ready} !== {4'b1000, 2'b01}) begin
                n_err++; $display("FAIL to_wait_c%0d: got %b/%b want 1000/01", k, status(), cop.rsp_ready);
            end
        end
        step();  // T+17: 16 cycles after entering REQ
        n_vec++;
        if ({status(), cx_err_code} !== {4'b1110, 2'b10}) begin
            n_err++; $display("FAIL to_err: got %b/%b want 1110/10", status(), cx_err_code);
        end
        step();
        n_vec++;
        if ({status(), cx_err_code} !== {4'b0000, 2'b10}) begin
            n_err++; $display("FAIL to_hold: got %b/%b want 0000/10", status(), cx_err_code);
        end
    endtask

    task automatic test_abort_rsp();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd1, 5'd9, OPC);
        step();  // T+1 REQ
        cx_vld = 1'b0; cop.req_ready = 2'b10;
        step();  // T+2 RSP
        cop.req_ready = '0; cx_abort = 1'b1;
        n_vec++;
        if (cop.rsp_ready !== 2'b10) begin n_err++; $display("FAIL ab_rsp_ready: got %b want 10", cop.rsp_ready); end
        for (int k = 3; k <= 6; k++) begin
            step();
            cx_abort = 1'b0;
            cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd0, 5'd2, OPC);
            cop.rsp_valid = (k == 6) ? 2'b10 : 2'b01;  // other channel must be ignored
            cop.rsp_rd    = {32'hDEAD, 32'hBEEF};
            n_vec++;
            if ({status(), cop.rsp_ready, cop.req_valid} !== {4'b1000, 2'b10, 2'b00}) begin
                n_err++; $display("FAIL ab_drain_c%0d: got %b/%b/%b want 1000/10/00",
                                  k, status(), cop.rsp_ready, cop.req_valid);
            end
        end
        step();  // T+7 back in IDLE
        quiet();
        n_vec++;
        if ({status(), cop.req_valid, cx_result} !== {4'b0000, 2'b00, 32'h1234}) begin
            n_err++; $display("FAIL ab_idle: got %b/%b/%h want 0000/00/1234", status(), cop.req_valid, cx_result);
        end
        step();
        n_vec++;
        if (status() !== 4'b0000) begin n_err++; $display("FAIL ab_no_accept: got %b want 0000", status()); end
    endtask

    task automatic test_abort_req();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd0, 5'd1, OPC);
        step();
        cx_vld = 1'b0; cx_abort = 1'b1;
        n_vec++;
        if (cop.req_valid !== 2'b01) begin n_err++; $display("FAIL abreq_valid: got %b want 01", cop.req_valid); end
        step();
        cx_abort = 1'b0;
        n_vec++;
        if ({status(), cop.req_valid} !== 6'd0) begin
            n_err++; $display("FAIL abreq_idle: got %b/%b want 0000/00", status(), cop.req_valid);
        end
    endtask

    task automatic test_back_to_back();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd0, 5'd1, OPC);
        step();  // REQ
        cx_vld = 1'b0; cop.req_ready = 2'b01;
        step();  // RSP
        cop.req_ready = '0; cop.rsp_valid = 2'b01; cop.rsp_rd = {32'h22, 32'h11};
        step();  // DONE: new instruction presented and held
        cop.rsp_valid = '0;
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd1, 5'd2, OPC);
        n_vec++;
        if ({status(), cx_result} !== {4'b1101, 32'h11}) begin
            n_err++; $display("FAIL b2b_done1: got %b/%h want 1101/11", status(), cx_result);
        end
        step();  // IDLE: accepted here
        n_vec++;
        if (status() !== 4'b0000) begin n_err++; $display("FAIL b2b_idle: got %b want 0000", status()); end
        step();  // REQ of second
        cx_vld = 1'b0; cop.req_ready = 2'b10;
        n_vec++;
        if (cop.req_valid !== 2'b10) begin n_err++; $display("FAIL b2b_req2: got %b want 10", cop.req_valid); end
        step();
        cop.req_ready = '0; cop.rsp_valid = 2'b10;
        step();
        cop.rsp_valid = '0;
        n_vec++;
        if ({status(), cx_result, cx_rd} !== {4'b1101, 32'h22, 5'd2}) begin
            n_err++; $display("FAIL b2b_done2: got %b/%h/%0d want 1101/22/2", status(), cx_result, cx_rd);
        end
        step();
    endtask

    task automatic test_reset_mid_and_rd0();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd0, 5'd6, OPC);
        step();
        cx_vld = 1'b0;
        n_vec++;
        if (cop.req_valid !== 2'b01) begin n_err++; $display("FAIL rst_pre: got %b want 01", cop.req_valid); end
        #2 rstz = 1'b0;
        #1;
        n_vec++;
        if ({cop.req_valid, status(), cx_rd, cx_result} !== '0) begin
            n_err++; $display("FAIL rst_async: got rv=%b st=%b rd=%0d want 0", cop.req_valid, status(), cx_rd);
        end
        @(negedge clk); rstz = 1'b1;
        step();
        cx_vld = 1'b1; cx_ir = mk_ir(7'h00, 3'd1, 5'd0, OPC);
        step();
        cx_vld = 1'b0; cop.req_ready = 2'b10;
        step();
        cop.req_ready = '0; cop.rsp_valid = 2'b10; cop.rsp_rd = {32'h77, 32'h0};
        step();
        cop.rsp_valid = '0;
        n_vec++;
        if ({status(), cx_result} !== {4'b1100, 32'h77}) begin
            n_err++; $display("FAIL rd0_done: got %b/%h want 1100/77", status(), cx_result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bad_instr();
        test_timeout();
        test_abort_rsp();
        test_abort_req();
        test_back_to_back();
        test_reset_mid_and_rd0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
